// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: opcode constants, hazard FSM states and
// operand-usage decode helpers.
package cpu_pkg;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {RUN, WAIT, ERR} hz_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: return 1'b1;
      OP_NOP:                                           return 1'b0;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_STORE, OP_RTYPE, OP_BRANCH: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-wait hazard controller for the 5-stage core,
// with a memory timeout trap and saturating stall/flush statistics.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             control_sel,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       lu, busy;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
               (uses_rs2(id_opcode) && (ex_rd == id_rs2)));
  assign busy = dmem_req && !dmem_ready;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    control_sel = 1'b0;
    if_id_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (reset || (state_q == ERR)) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      control_sel = 1'b1;
      pipe_freeze = 1'b1;
    end else if (busy) begin
      // ID/EX is held rather than bubbled, so control_sel stays low.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      control_sel = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      control_sel = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (busy) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        if (dmem_ready || !dmem_req) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
    mem_err_d = mem_err_q || (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!reset && !pc_write),
    .q    (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (if_id_flush),
    .q    (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. Watches the ID, EX and MEM stages and drives `control_sel` into `control_path`, so a 1 forces an all-zero (nop) control word into ID/EX. It also drives PC/IF-ID write enables, branch flushes and a full-pipeline freeze while data memory is busy. It has a memory-wait state machine with timeout, and saturating stall/flush statistics counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles before `mem_err`; legal range 1–255.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_opcode`  in  7  opcode of the instruction in IF/ID.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in IF/ID.
- `ex_rd`  in  5  destination register held in ID/EX.
- `ex_memread`  in  1  ID/EX.MemRead.
- `ex_branch_taken`  in  1  branch in EX is resolved taken.
- `dmem_req`  in  1  MEM stage is accessing memory (MemRead | MemWrite).
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID register enable.
- `control_sel`  out  1  1 forces a nop into ID/EX.
- `if_id_flush`  out  1  clears IF/ID to nop.
- `pipe_freeze`  out  1  holds ID/EX, EX/MEM and MEM/WB.
- `mem_err`  out  1  sticky memory timeout flag.
- `stall_cnt`  out  `CNT_W`  number of stalled cycles.
- `flush_cnt`  out  `CNT_W`  number of flush events.

## Operation
- States: RUN, WAIT, ERR. The state register, wait counter, `mem_err` and both statistics counters are registered. All other outputs are combinational from the state and the current inputs.
- Operand use by opcode:
  - rs1 is used by 0000011, 0100011, 0110011, 0010011 and 1100011.
  - rs2 is used by 0100011, 0110011 and 1100011.
  - Opcode 0000000 (nop) uses neither.
  - Register x0 never creates a hazard.
- Load-use: `lu = ex_memread & ex_rd != 0 & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2))`.
- Memory busy: `busy = dmem_req & !dmem_ready`.
- Output priority (highest first):
  1. Reset or ERR: `pc_write=0`, `if_id_write=0`, `control_sel=1`, `pipe_freeze=1`, `if_id_flush=0`.
  2. `busy`: `pipe_freeze=1`, `pc_write=0`, `if_id_write=0`, `control_sel=0`. The ID/EX contents are held, not bubbled.
  3. `ex_branch_taken`: `if_id_flush=1`, `control_sel=1`, `pc_write=1`, `if_id_write=1`.
  4. `lu`: `pc_write=0`, `if_id_write=0`, `control_sel=1`.
  5. Otherwise: `pc_write=1`, `if_id_write=1`, every other output 0.
- Transitions:
  - RUN → WAIT when `busy`; the wait counter loads 1.
  - WAIT → RUN when `dmem_ready`, or when `!dmem_req` (the request was withdrawn).
  - WAIT → ERR when `busy` and the wait counter equals `MEM_TIMEOUT`.
  - WAIT stays in WAIT otherwise, and the wait counter increments.
  - ERR is left only by `reset`.
- `stall_cnt` increments in every post-reset cycle with `pc_write=0`. `flush_cnt` increments in every cycle with `if_id_flush=1`. Both saturate at all-ones and never wrap.
- A branch taken while `busy` is ignored that cycle. It is re-evaluated once the freeze lifts, because EX is held.

## Timing
- Hazard outputs have zero latency: they respond in the same cycle as the inputs.
- A load-use stall lasts exactly one cycle. The next cycle the bubble sits in ID/EX and `ex_memread=0`.
- Freeze lasts one cycle per `busy` cycle. It releases in the same cycle `dmem_ready` rises.
- `mem_err` rises the cycle after the `busy` cycle in which the counter equals `MEM_TIMEOUT`. That is `MEM_TIMEOUT+1` consecutive busy cycles, with `mem_err` high on the next edge.
- Reset values: state RUN, wait counter 0, `mem_err=0`, `stall_cnt=0`, `flush_cnt=0`.
- Reset asserted mid-WAIT returns to RUN on the next edge. The counters do not advance in reset cycles.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_NOP`, `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`;
  - the state enum `hz_state_t` (RUN, WAIT, ERR).
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `q`), instantiated twice, once for each statistics counter.

## Test plan
- Load-use stall: `ex_memread=1`, `ex_rd=5`, `id_opcode=0110011`, `id_rs2=5` → for one cycle `pc_write=0`, `if_id_write=0`, `control_sel=1`; `stall_cnt` goes 0→1.
- x0 and unused-operand cases produce no stall:
  - `ex_rd=0` matching `id_rs1=0` → no stall;
  - `ex_rd=7` with `id_opcode=0010011` and `id_rs2=7` → no stall.
- Branch versus load-use collision: `ex_branch_taken=1` and `lu` true in the same cycle → `if_id_flush=1`, `pc_write=1`, `control_sel=1`; `flush_cnt=1`, `stall_cnt` unchanged.
- Memory wait: `dmem_req=1`, `dmem_ready=0` for 3 cycles, then `dmem_ready=1` → `pipe_freeze=1` for 3 cycles, released on cycle 4; state returns to RUN; `stall_cnt=3`.
- Timeout: `MEM_TIMEOUT=4`, `busy` held for 5 cycles → `mem_err=1` on the next edge; outputs stay frozen until `reset`, which clears `mem_err`.
- Saturation: `CNT_W=4`, 20 load-use stalls → `stall_cnt` holds at 15.
